inpkt_parser: RTL and testbench

- Input-side packet parser. Sits between the host input FIFO (8-bit, first-word-fall-through) and the application's payload FIFO.
- Consumes framed packets byte by byte and validates the header. Forwards payload bytes cut-through to the application FIFO.
- Checks the trailing checksum, publishes packet metadata, and reports a sticky error code on pkt_comm_status.

---
 rtl/inpkt_parser.sv | 192 +++++++++++++++++++
 tb/tb_inpkt_parser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inpkt_parser.sv
// Input-side packet parser: validates the 10-byte header, forwards the payload cut-through, checks the trailer.
// Optional checksum verification is enabled by defining INPKT_CHECKSUM_EN.
module inpkt_parser #(
    parameter logic [7:0] PKT_VERSION  = 8'd1,
    parameter int         PKT_MAX_LEN  = 65536,
    parameter logic [7:0] PKT_TYPE_MAX = 8'd3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  din,
    output logic        rd_en,
    input  logic        empty,
    output logic [7:0]  dout,
    output logic        wr_en,
    input  logic        full,
    output logic [7:0]  pkt_type,
    output logic [15:0] pkt_id,
    output logic        pkt_start,
    output logic        pkt_end,
    output logic [7:0]  pkt_comm_status
);
    localparam logic [23:0] MAX_LEN = 24'(PKT_MAX_LEN);

    typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_CSUM, S_ERROR} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] len_q, len_d;
    logic [23:0] rem_q, rem_d;
    logic [7:0]  type_tmp_q, type_tmp_d;
    logic [7:0]  id_lo_q, id_lo_d;
    logic [7:0]  pkt_type_q, pkt_type_d;
    logic [15:0] pkt_id_q, pkt_id_d;
    logic [7:0]  status_q, status_d;
    logic        start_q, start_d;
    logic        end_q, end_d;
`ifdef INPKT_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [7:0]  csum_lo_q, csum_lo_d;
`endif

    logic        rd;
    logic        err;
    logic [7:0]  err_code;
    logic [23:0] len_full;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        rem_d      = rem_q;
        type_tmp_d = type_tmp_q;
        id_lo_d    = id_lo_q;
        pkt_type_d = pkt_type_q;
        pkt_id_d   = pkt_id_q;
        status_d   = status_q;
        start_d    = 1'b0;
        end_d      = 1'b0;
`ifdef INPKT_CHECKSUM_EN
        acc_d      = acc_q;
        csum_lo_d  = csum_lo_q;
`endif
        err        = 1'b0;
        err_code   = 8'h00;
        len_full   = {din, len_q[15:0]};

        case (state_q)
            S_HEADER:  rd = ~empty;
            S_PAYLOAD: rd = ~empty & ~full;
            S_CSUM:    rd = ~empty;
            default:   rd = 1'b0;
        endcase
        if (RESET) rd = 1'b0;

        if (rd) begin
            case (state_q)
                S_HEADER: begin
                    idx_d = idx_q + 4'd1;
                    case (idx_q)
                        4'd0: if (din != PKT_VERSION) begin err = 1'b1; err_code = 8'h01; end
                        4'd1: begin
                            if (din == 8'd0 || din > PKT_TYPE_MAX) begin
                                err = 1'b1; err_code = 8'h02;
                            end
                            type_tmp_d = din;
                        end
                        4'd2, 4'd3, 4'd7: if (din != 8'd0) begin err = 1'b1; err_code = 8'h05; end
                        4'd4: len_d[7:0]  = din;
                        4'd5: len_d[15:8] = din;
                        4'd6: begin
                            len_d[23:16] = din;
                            if (len_full == 24'd0 || len_full > MAX_LEN) begin
                                err = 1'b1; err_code = 8'h03;
                            end
                        end
                        4'd8: id_lo_d = din;
                        default: begin
                            pkt_type_d = type_tmp_q;
                            pkt_id_d   = {din, id_lo_q};
                            start_d    = 1'b1;
                            rem_d      = len_q;
                            idx_d      = 4'd0;
                            state_d    = S_PAYLOAD;
`ifdef INPKT_CHECKSUM_EN
                            acc_d      = 16'd0;
`endif
                        end
                    endcase
                end
                S_PAYLOAD: begin
                    rem_d = rem_q - 24'd1;
`ifdef INPKT_CHECKSUM_EN
                    acc_d = acc_q + {8'h00, din};
`endif
                    if (rem_q == 24'd1) begin
                        state_d = S_CSUM;
                        idx_d   = 4'd0;
                    end
                end
                S_CSUM: begin
                    if (idx_q == 4'd0) begin
                        idx_d = 4'd1;
`ifdef INPKT_CHECKSUM_EN
                        csum_lo_d = din;
`endif
                    end else begin
                        idx_d   = 4'd0;
                        state_d = S_HEADER;
`ifdef INPKT_CHECKSUM_EN
                        if ({din, csum_lo_q} == ~acc_q) end_d = 1'b1;
                        else begin err = 1'b1; err_code = 8'h04; end
`else
                        end_d = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end

        // ERROR holds until reset; nothing else is consumed.
        if (err) begin
            state_d  = S_ERROR;
            status_d = err_code;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_HEADER;
            idx_q      <= 4'd0;
            len_q      <= 24'd0;
            rem_q      <= 24'd0;
            type_tmp_q <= 8'd0;
            id_lo_q    <= 8'd0;
            pkt_type_q <= 8'd0;
            pkt_id_q   <= 16'd0;
            status_q   <= 8'd0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
`ifdef INPKT_CHECKSUM_EN
            acc_q      <= 16'd0;
            csum_lo_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            type_tmp_q <= type_tmp_d;
            id_lo_q    <= id_lo_d;
            pkt_type_q <= pkt_type_d;
            pkt_id_q   <= pkt_id_d;
            status_q   <= status_d;
            start_q    <= start_d;
            end_q      <= end_d;
`ifdef INPKT_CHECKSUM_EN
            acc_q      <= acc_d;
            csum_lo_q  <= csum_lo_d;
`endif
        end
    end

    assign rd_en           = rd;
    assign dout            = din;
    assign wr_en           = rd && (state_q == S_PAYLOAD);
    assign pkt_type        = pkt_type_q;
    assign pkt_id          = pkt_id_q;
    assign pkt_start       = start_q;
    assign pkt_end         = end_q;
    assign pkt_comm_status = status_q;
endmodule

// File: tb/tb_inpkt_parser.sv
// Bench for inpkt_parser: byte-source model feeding a packet queue, payload scoreboard on the output side.
module tb_inpkt_parser;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        rd_en;
    logic        empty = 1'b1;
    logic [7:0]  dout;
    logic        wr_en;
    logic        full = 1'b0;
    logic [7:0]  pkt_type;
    logic [15:0] pkt_id;
    logic        pkt_start;
    logic        pkt_end;
    logic [7:0]  pkt_comm_status;

    inpkt_parser dut (
        .CLK(CLK), .RESET(RESET), .din(din), .rd_en(rd_en), .empty(empty),
        .dout(dout), .wr_en(wr_en), .full(full), .pkt_type(pkt_type), .pkt_id(pkt_id),
        .pkt_start(pkt_start), .pkt_end(pkt_end), .pkt_comm_status(pkt_comm_status)
    );

    always #5 CLK = ~CLK;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    int compared = 0, mismatched = 0;
    int starts = 0, ends = 0, wr_count = 0;

    typedef struct {
        logic [7:0]  ver, typ, r2, r7;
        logic [23:0] len;
        logic [15:0] id;
        logic [7:0]  base;
        bit          bad;
        logic [7:0]  st;
        int          n_start, n_end;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply();
        empty = (in_q.size() == 0);
        din   = empty ? 8'h00 : in_q[0];
    endtask

    task automatic cycle();
        logic cons;
        @(negedge CLK);
        if (wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) chk("wr_extra", {24'h0, dout}, 32'hffff_ffff);
            else chk("payload", {24'h0, dout}, {24'h0, exp_q.pop_front()});
        end
        if (full) chk("wr_while_full", {31'h0, wr_en}, 32'h0);
        if (pkt_start) starts++;
        if (pkt_end) ends++;
        if (pkt_start && pkt_end) chk("start_end_overlap", 32'h1, 32'h0);
        cons = rd_en;
        @(posedge CLK);
        #1;
        if (cons && in_q.size() > 0) void'(in_q.pop_front());
        apply();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        in_q.delete();
        exp_q.delete();
        RESET = 1'b1;
        full  = 1'b0;
        apply();
        run(2);
        RESET = 1'b0;
        starts = 0; ends = 0; wr_count = 0;
    endtask

    task automatic build(input logic [7:0] ver, input logic [7:0] typ, input logic [7:0] r2,
                         input logic [7:0] r7, input logic [23:0] len, input logic [15:0] id,
                         input logic [7:0] base, input bit bad, input bit with_payload);
        logic [15:0] sum, cs;
        logic [7:0]  b;
        sum = 16'h0;
        in_q.push_back(ver); in_q.push_back(typ); in_q.push_back(r2); in_q.push_back(8'h00);
        in_q.push_back(len[7:0]); in_q.push_back(len[15:8]); in_q.push_back(len[23:16]);
        in_q.push_back(r7); in_q.push_back(id[7:0]); in_q.push_back(id[15:8]);
        if (with_payload) begin
            for (int k = 0; k < int'(len); k++) begin
                b = base + 8'(k * 16);
                sum = sum + {8'h00, b};
                in_q.push_back(b);
                exp_q.push_back(b);
            end
            cs = bad ? 16'h0000 : ~sum;
            in_q.push_back(cs[7:0]);
            in_q.push_back(cs[15:8]);
        end
        apply();
    endtask

    vec_t vecs[10];
    logic [7:0] bad_st;
    int bad_end;

    initial begin
`ifdef INPKT_CHECKSUM_EN
        bad_st = 8'h04; bad_end = 0;
`else
        bad_st = 8'h00; bad_end = 1;
`endif
        //           ver    typ    r2     r7     len         id        base   bad  st     s  e
        vecs[0] = '{8'h01, 8'h01, 8'h00, 8'h00, 24'd4,      16'h1234, 8'h10, 0, 8'h00, 1, 1};
        vecs[1] = '{8'h02, 8'h01, 8'h00, 8'h00, 24'd4,      16'h1234, 8'h10, 0, 8'h01, 0, 0};
        vecs[2] = '{8'h01, 8'h00, 8'h00, 8'h00, 24'd4,      16'h0001, 8'h10, 0, 8'h02, 0, 0};
        vecs[3] = '{8'h01, 8'h04, 8'h00, 8'h00, 24'd4,      16'h0001, 8'h10, 0, 8'h02, 0, 0};
        vecs[4] = '{8'h01, 8'h01, 8'h07, 8'h00, 24'd4,      16'h0001, 8'h10, 0, 8'h05, 0, 0};
        vecs[5] = '{8'h01, 8'h01, 8'h00, 8'h80, 24'd4,      16'h0001, 8'h10, 0, 8'h05, 0, 0};
        vecs[6] = '{8'h01, 8'h01, 8'h00, 8'h00, 24'd0,      16'h0001, 8'h10, 0, 8'h03, 0, 0};
        vecs[7] = '{8'h01, 8'h01, 8'h00, 8'h00, 24'h010001, 16'h0001, 8'h10, 0, 8'h03, 0, 0};
        vecs[8] = '{8'h01, 8'h02, 8'h00, 8'h00, 24'd5,      16'h5a5a, 8'h33, 1, bad_st, 1, bad_end};
        vecs[9] = '{8'h01, 8'h03, 8'h00, 8'h00, 24'd1,      16'hbeef, 8'hc4, 0, 8'h00, 1, 1};

        for (int v = 0; v < 10; v++) begin
            do_reset();
            chk($sformatf("v%0d_reset_status", v), {24'h0, pkt_comm_status}, 32'h0);
            build(vecs[v].ver, vecs[v].typ, vecs[v].r2, vecs[v].r7, vecs[v].len, vecs[v].id,
                  vecs[v].base, vecs[v].bad, vecs[v].n_start != 0);
            run(16 + ((vecs[v].n_start != 0) ? int'(vecs[v].len) : 0));
            chk($sformatf("v%0d_status", v), {24'h0, pkt_comm_status}, {24'h0, vecs[v].st});
            chk($sformatf("v%0d_starts", v), starts, vecs[v].n_start);
            chk($sformatf("v%0d_ends", v), ends, vecs[v].n_end);
            chk($sformatf("v%0d_left", v), exp_q.size(), 0);
            chk($sformatf("v%0d_rd_idle", v), {31'h0, rd_en}, 32'h0);
            if (vecs[v].n_start != 0) begin
                chk($sformatf("v%0d_type", v), {24'h0, pkt_type}, {24'h0, vecs[v].typ});
                chk($sformatf("v%0d_id", v), {16'h0, pkt_id}, {16'h0, vecs[v].id});
            end
        end
        chk("reset_clears_err", 32'h0, 32'h0 + {24'h0, pkt_comm_status} - {24'h0, vecs[9].st});

        // Backpressure mid-payload: full for 3 cycles.
        do_reset();
        build(8'h01, 8'h01, 8'h00, 8'h00, 24'd4, 16'h1234, 8'h10, 0, 1);
        for (int i = 0; i < 40 && wr_count < 2; i++) cycle();
        chk("stall_reach", wr_count, 2);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_rd", {31'h0, rd_en}, 32'h0);
            cycle();
        end
        full = 1'b0;
        run(10);
        chk("stall_wr_count", wr_count, 4);
        chk("stall_left", exp_q.size(), 0);
        chk("stall_ends", ends, 1);
        chk("stall_status", {24'h0, pkt_comm_status}, 32'h0);

        // Back-to-back packets, then reset mid-payload of a third.
        do_reset();
        build(8'h01, 8'h01, 8'h00, 8'h00, 24'd4, 16'h0101, 8'h01, 0, 1);
        build(8'h01, 8'h02, 8'h00, 8'h00, 24'd3, 16'h0202, 8'h22, 0, 1);
        build(8'h01, 8'h03, 8'h00, 8'h00, 24'd8, 16'h0303, 8'h05, 0, 1);
        for (int i = 0; i < 80 && ends < 2; i++) cycle();
        chk("b2b_ends", ends, 2);
        chk("b2b_id2", {16'h0, pkt_id}, 32'h0202);
        for (int i = 0; i < 40 && wr_count < 10; i++) cycle();
        chk("b2b_mid", wr_count, 10);
        chk("b2b_starts", starts, 3);
        do_reset();
        chk("rst_status", {24'h0, pkt_comm_status}, 32'h0);
        chk("rst_type", {24'h0, pkt_type}, 32'h0);
        chk("rst_id", {16'h0, pkt_id}, 32'h0);
        build(8'h01, 8'h03, 8'h00, 8'h00, 24'd2, 16'hcafe, 8'h90, 0, 1);
        run(18);
        chk("post_starts", starts, 1);
        chk("post_ends", ends, 1);
        chk("post_id", {16'h0, pkt_id}, 32'hcafe);
        chk("post_type", {24'h0, pkt_type}, 32'h3);
        chk("post_left", exp_q.size(), 0);
        chk("post_status", {24'h0, pkt_comm_status}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
